// File: rtl/zx_sound_ports_n.sv
// zx_sound_ports_n: Z80 port decoder and sound control for the ZX sound board (TurboSound select, AY bus, beeper, covox, YM clock).
// Covox port #FB is built only when ZX_SOUND_PORTS_COVOX_EN is defined.
module zx_sound_ports_n #(
    parameter int         NUM_CHIPS  = 2,
    parameter int         YM_CLK_DIV = 2,
    parameter logic [3:0] COVOX_ADDR = 4'hB
) (
    input  logic                 cpu_clock,
    input  logic                 reset,
    input  logic [15:0]          a,
    input  logic [7:0]           d,
    input  logic                 m1,
    input  logic                 iorq,
    input  logic                 wr,
    input  logic                 rd,
    input  logic                 div_bypass,
    output logic                 bdir,
    output logic                 bc1,
    output logic [NUM_CHIPS-1:0] ym_sel,
    output logic                 ym_clock,
    output logic [7:0]           covox_data,
    output logic                 covox_strobe,
    output logic                 beeper,
    output logic                 tapeout,
    output logic                 ioge_c
);
    localparam int HALF = YM_CLK_DIV / 2;

    logic                 w_ay_addr, w_ay_hit, w_ts_code, w_ts_blk, w_ts_ok;
    logic                 w_wr_cyc, w_event, w_cov_ev, w_unused;
    logic [2:0]           w_ts_idx;
    logic                 r_wr_cyc_q, r_ym_div, r_ioge, r_beeper, r_tapeout;
    logic [3:0]           r_div_cnt;
    logic [NUM_CHIPS-1:0] r_ym_sel;

    assign w_ay_addr = a[0] & ~a[1] & a[2] & a[3] & a[13] & a[15] & m1;
    assign w_ay_hit  = w_ay_addr & ~iorq;
    assign w_ts_code = d[7:3] == 5'b11111;
    assign w_ts_idx  = 3'd7 - d[2:0];
    assign w_ts_ok   = int'(w_ts_idx) < NUM_CHIPS;
    // any 0xF8..0xFF write to #FFFD is a select byte and must never reach the AY
    assign w_ts_blk  = w_ay_hit & a[14] & ~wr & w_ts_code;
    assign w_wr_cyc  = ~iorq & ~wr & m1;
    assign w_event   = w_wr_cyc & ~r_wr_cyc_q;
    assign w_cov_ev  = w_event & (a[3:0] == COVOX_ADDR);

    assign bdir     = w_ay_hit & ~wr & ~w_ts_blk;
    assign bc1      = w_ay_hit & a[14] & (~wr | ~rd) & ~w_ts_blk;
    assign ym_sel   = r_ym_sel;
    assign ym_clock = div_bypass ? cpu_clock : r_ym_div;
    assign beeper   = r_beeper;
    assign tapeout  = r_tapeout;
    assign ioge_c   = r_ioge;

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            r_wr_cyc_q <= 1'b1;
            r_ioge     <= 1'b0;
            r_ym_sel   <= NUM_CHIPS'(1);
            r_beeper   <= 1'b0;
            r_tapeout  <= 1'b0;
            r_div_cnt  <= 4'd0;
            r_ym_div   <= 1'b0;
        end else begin
            r_wr_cyc_q <= w_wr_cyc;
            r_ioge     <= w_ay_addr;
            r_div_cnt  <= (r_div_cnt == 4'(HALF - 1)) ? 4'd0 : r_div_cnt + 4'd1;
            r_ym_div   <= (r_div_cnt == 4'(HALF - 1)) ? ~r_ym_div : r_ym_div;
            if (w_event & w_ay_hit & a[14] & w_ts_code & w_ts_ok)
                r_ym_sel <= NUM_CHIPS'(1) << w_ts_idx;
            if (w_event & ~a[0] & a[1] & a[2] & a[3]) begin
                r_beeper  <= d[4];
                r_tapeout <= d[3];
            end
        end
    end

`ifdef ZX_SOUND_PORTS_COVOX_EN
    logic [7:0] r_covox_data;
    logic       r_covox_strobe;

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            r_covox_data   <= 8'h00;
            r_covox_strobe <= 1'b0;
        end else begin
            r_covox_strobe <= w_cov_ev;
            if (w_cov_ev)
                r_covox_data <= d;
        end
    end

    assign covox_data   = r_covox_data;
    assign covox_strobe = r_covox_strobe;
    assign w_unused     = ^a[12:4];
`else
    assign covox_data   = 8'h00;
    assign covox_strobe = 1'b0;
    assign w_unused     = ^{a[12:4], w_cov_ev};
`endif
endmodule

// File: tb/tb_zx_sound_ports_n.sv
// tb_zx_sound_ports_n: directed and randomized port writes checked against a port-level model of the sound block.
module tb_zx_sound_ports_n;
    logic        cpu_clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d = 8'h00;
    logic        m1 = 1'b1, iorq = 1'b1, wr = 1'b1, rd = 1'b1, div_bypass = 1'b0;
    logic        bdir, bc1, ym_clock, covox_strobe, beeper, tapeout, ioge_c;
    logic [1:0]  ym_sel;
    logic [7:0]  covox_data;

    int          checks = 0, errors = 0, n = 0;
    logic [1:0]  e_sel = 2'b01;
    logic        e_beep = 1'b0, e_tape = 1'b0;
    logic [7:0]  e_cov = 8'h00;

    zx_sound_ports_n #(.NUM_CHIPS(2), .YM_CLK_DIV(4), .COVOX_ADDR(4'hB)) dut (
        .cpu_clock(cpu_clock), .reset(reset), .a(a), .d(d), .m1(m1), .iorq(iorq),
        .wr(wr), .rd(rd), .div_bypass(div_bypass), .bdir(bdir), .bc1(bc1),
        .ym_sel(ym_sel), .ym_clock(ym_clock), .covox_data(covox_data),
        .covox_strobe(covox_strobe), .beeper(beeper), .tapeout(tapeout), .ioge_c(ioge_c)
    );

    always #5 cpu_clock = ~cpu_clock;
    always @(posedge cpu_clock) n <= reset ? 0 : n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic idle();
        iorq = 1'b1; wr = 1'b1; rd = 1'b1; m1 = 1'b1; a = 16'h0000; d = 8'h00;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_sel"}, 32'(ym_sel), 32'(e_sel));
        chk({tag, "_beep"}, 32'(beeper), 32'(e_beep));
        chk({tag, "_tape"}, 32'(tapeout), 32'(e_tape));
        chk({tag, "_cov"}, 32'(covox_data), 32'(e_cov));
    endtask

    function automatic bit covox_on();
`ifdef ZX_SOUND_PORTS_COVOX_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // expected AY strobes for a write: select bytes to #FFFD are swallowed
    function automatic logic [1:0] exp_bus(input logic [15:0] addr, input logic [7:0] data);
        if (addr == 16'hFFFD) return (data >= 8'hF8) ? 2'b00 : 2'b11;
        if (addr == 16'hBFFD) return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input logic [15:0] addr, input logic [7:0] data);
        if (addr == 16'hFFFD && data == 8'hFF) e_sel = 2'b01;
        if (addr == 16'hFFFD && data == 8'hFE) e_sel = 2'b10;
        if (addr[7:0] == 8'hFE) begin e_beep = data[4]; e_tape = data[3]; end
        if (covox_on() && addr[7:0] == 8'hFB) e_cov = data;
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
        logic ay, cov;
        ay  = (addr == 16'hFFFD) || (addr == 16'hBFFD);
        cov = covox_on() && addr[7:0] == 8'hFB;
        a = addr; d = data; iorq = 1'b0; wr = 1'b0; m1 = 1'b1;
        #1;
        chk("bus_first", 32'({bdir, bc1}), 32'(exp_bus(addr, data)));
        check_state("pre");
        apply(addr, data);
        tick();
        check_state("edge");
        chk("strobe_edge", 32'(covox_strobe), 32'(cov));
        chk("ioge", 32'(ioge_c), 32'(ay));
        for (int i = 1; i < hold; i++) begin
            tick();
            chk("bus_hold", 32'({bdir, bc1}), 32'(exp_bus(addr, data)));
            chk("strobe_hold", 32'(covox_strobe), 32'h0);
            check_state("hold");
        end
        idle();
        tick();
        chk("strobe_off", 32'(covox_strobe), 32'h0);
    endtask

    initial begin
        logic [7:0]  rd8;
        logic [15:0] addr;
        int          kind;
        tick();
        tick();
        check_state("reset");
        chk("reset_ym", 32'(ym_clock), 32'h0);
        chk("reset_strobe", 32'(covox_strobe), 32'h0);
        chk("reset_ioge", 32'(ioge_c), 32'h0);
        reset = 1'b0;
        tick();

        io_write(16'hFFFD, 8'hFE, 4);
        io_write(16'hFFFD, 8'hFF, 1);
        io_write(16'hFFFD, 8'hFE, 2);
        io_write(16'hFFFD, 8'hFD, 2);
        io_write(16'hFFFD, 8'h07, 2);
        io_write(16'hBFFD, 8'h55, 1);
        io_write(16'hBFFD, 8'hFF, 1);
        io_write(16'h00FB, 8'hA5, 3);
        io_write(16'h00FE, 8'h18, 2);
        io_write(16'h00FE, 8'h00, 1);

        a = 16'hFFFD; iorq = 1'b0; rd = 1'b0;
        #1;
        chk("bus_read", 32'({bdir, bc1}), 32'h1);
        idle();
        tick();

        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 3));
            rd8  = 8'($urandom);
            case (kind)
                0: begin addr = 16'hFFFD; if ($urandom_range(0, 1) == 1) rd8[7:3] = 5'b11111; end
                1: addr = 16'hBFFD;
                2: addr = {8'($urandom), 8'hFE};
                default: addr = {8'($urandom), 8'hFB};
            endcase
            io_write(addr, rd8, int'($urandom_range(1, 4)));
        end

        a = 16'h00FE; d = 8'h18; iorq = 1'b0; wr = 1'b0;
        apply(16'h00FE, 8'h18);
        tick();
        check_state("mid_latch");
        reset = 1'b1;
        tick();
        e_sel = 2'b01; e_beep = 1'b0; e_tape = 1'b0; e_cov = 8'h00;
        check_state("mid_reset");
        reset = 1'b0;
        tick();
        tick();
        check_state("mid_release");
        idle();
        tick();

        for (int k = 0; k < 12; k++) begin
            tick();
            chk("ym_div", 32'(ym_clock), 32'((n / 2) % 2));
        end
        div_bypass = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ym_bypass_hi", 32'(ym_clock), 32'h1);
            @(negedge cpu_clock);
            #1;
            chk("ym_bypass_lo", 32'(ym_clock), 32'h0);
        end
        div_bypass = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
